mod_add_arbiter: RTL and testbench
==================================

Name: mod_add_arbiter

Overview:
- Shares one modular addition unit ((a + b) mod p, 64-bit, single-cycle registered, start/finish pulse interface) between NUM_REQ requesters inside the ECC accelerator, e.g. point-add and point-double sequencers.
- Round-robin grant with valid/ready request and response handshakes.
- Operand latching, one-cycle start pulse generation, result capture, and a watchdog timeout that returns an error response if the adder never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/result width; must match the adder.
- TIMEOUT, 16, max WAIT cycles before an error response (>= 1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester request accept, one-hot or zero.
- req_a_i  input  NUM_REQ*WIDTH  operand A; requester k in slice [k*WIDTH +: WIDTH].
- req_b_i  input  NUM_REQ*WIDTH  operand B, same packing.
- req_p_i  input  NUM_REQ*WIDTH  modulus P, same packing.
- resp_valid_o  output  NUM_REQ  per-requester response valid, one-hot or zero.
- resp_ready_i  input  NUM_REQ  per-requester response accept.
- resp_result_o  output  WIDTH  result, shared by all requesters.
- resp_err_o  output  1  response is a timeout error; result is 0.
- add_start_o  output  1  start pulse to the adder.
- add_a_o, add_b_o, add_p_o  output  WIDTH each  adder operands.
- add_finish_i  input  1  adder finish.
- add_result_i  input  WIDTH  adder result.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; all outputs 0; operand/result registers 0; timeout counter 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted in any state aborts the transaction immediately. No response is produced for an in-flight request. The requester must re-issue after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first k with req_valid_i[k]=1, searching from rr+1 upward and wrapping mod NUM_REQ.
  - req_ready_o[g]=1, combinational, in the same cycle; nothing granted if no valid.
  - On handshake: latch a/b/p slices of g and g into registers; next state ISSUE.
- ISSUE: add_start_o=1 for exactly this cycle; add_a/b/p_o driven from the latched registers (held stable through WAIT); counter cleared; next state WAIT.
- WAIT: add_start_o=0.
  - If add_finish_i=1: latch add_result_i, err=0; next state RESP.
  - Else counter increments. When counter reaches TIMEOUT-1 without finish: result=0, err=1; next state RESP.
  - Finish takes precedence over timeout in the same cycle.
- RESP: resp_valid_o[g]=1, with resp_result_o/resp_err_o stable until resp_ready_i[g]=1.
  - On that handshake: rr <= g; next state IDLE.
  - resp_ready_i of other requesters is ignored.
- Outside RESP, resp_valid_o=0, resp_result_o=0, resp_err_o=0.
- Latency from request handshake cycle T: add_start_o at T+1, finish sampled at T+2, resp_valid_o at T+3. Minimum 4 cycles per transaction, including the return to IDLE.
- Only one transaction in flight; req_ready_o is all-zero outside IDLE.
- Requesters hold valid and operands until ready; dropping valid before ready is legal (no grant).
- add_finish_i outside WAIT is ignored.
- No arithmetic is performed in this block; operands pass through unchanged. a, b < p is the requester's responsibility.

Test Plan:
- Single request, requester 0: a=5, b=7, p=11 -> add_start_o pulse at T+1 with 5/7/11; resp_valid_o[0] at T+3; resp_result_o=1; resp_err_o=0.
- Fairness: all 4 requesters valid continuously from reset; req k uses a=k, b=1, p=100 -> grants in order 0,1,2,3,0; results 1,2,3,4,1; exactly one req_ready_o bit per IDLE cycle.
- Backpressure: resp_ready_i[2]=0 for 5 cycles during RESP -> resp_valid_o[2] and result held stable; req_ready_o stays 0 despite other valids; accept resumes the cycle after the handshake.
- Timeout: add_finish_i tied 0, TIMEOUT=16 -> after 16 WAIT cycles, resp_valid_o set with resp_err_o=1 and resp_result_o=0; next request then proceeds normally.
- Wrap: a=2^64-2, b=5, p=2^64-1 on the adder model -> resp_result_o=4; operands on add_*_o unchanged from request.
- Reset in WAIT: pull rst_ni low -> outputs 0 immediately. After release, no response for the aborted request; requester 0 is granted first.

Source files
------------

// File: rtl/mod_add_arbiter.sv
// mod_add_arbiter: round-robin share of one modular adder
// between NUM_REQ requesters, with a watchdog timeout.
module mod_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_p_i,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   input  logic [NUM_REQ-1:0]       resp_ready_i,
   output logic [WIDTH-1:0]         resp_result_o,
   output logic                     resp_err_o,
   output logic                     add_start_o,
   output logic [WIDTH-1:0]         add_a_o,
   output logic [WIDTH-1:0]         add_b_o,
   output logic [WIDTH-1:0]         add_p_o,
   input  logic                     add_finish_i,
   input  logic [WIDTH-1:0]         add_result_i,
   output logic                     busy_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] rr_q;
   logic [IDX_W-1:0] gnt_q;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] idx;
   logic             gnt_vld;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] p_sel;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_hs;
   logic             resp_hs;
   logic             tmo;

   assign req_hs  = (state_q == IDLE) && gnt_vld;
   assign resp_hs = (state_q == RESP) && resp_ready_i[gnt_q];
   assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign add_a_o = a_q;
   assign add_b_o = b_q;
   assign add_p_o = p_q;

   // Search for a valid requester starting just after the last one served.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((int'(rr_q) + i) % NUM_REQ);
         if (!gnt_vld && req_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   // Operand slices of the requester that would be granted.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      p_sel = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_idx == IDX_W'(k)) begin
            a_sel = req_a_i[k*WIDTH +: WIDTH];
            b_sel = req_b_i[k*WIDTH +: WIDTH];
            p_sel = req_p_i[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept, only while idle and out of reset.
   always_comb begin
      req_ready_o = '0;
      if (rst_ni && req_hs) begin
         req_ready_o[gnt_idx] = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      add_start_o   = 1'b0;
      resp_valid_o  = '0;
      resp_result_o = '0;
      resp_err_o    = 1'b0;
      busy_o        = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (req_hs) state_d = ISSUE;
         end
         ISSUE: begin
            add_start_o = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            if (add_finish_i || tmo) state_d = RESP;
         end
         RESP: begin
            resp_valid_o[gnt_q] = 1'b1;
            resp_result_o       = res_q;
            resp_err_o          = err_q;
            if (resp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand/grant latch, watchdog, result capture, rr pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         gnt_q <= '0;
         res_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
         rr_q  <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (req_hs) begin
            a_q   <= a_sel;
            b_q   <= b_sel;
            p_q   <= p_sel;
            gnt_q <= gnt_idx;
         end
         if (state_q == ISSUE) begin
            cnt_q <= '0;
         end else if (state_q == WAIT && !add_finish_i && !tmo) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (state_q == WAIT) begin
            if (add_finish_i) begin
               res_q <= add_result_i;
               err_q <= 1'b0;
            end else if (tmo) begin
               res_q <= '0;
               err_q <= 1'b1;
            end
         end
         if (resp_hs) begin
            rr_q <= gnt_q;
         end
      end
   end

endmodule

// File: tb/tb_mod_add_arbiter.sv
// tb_mod_add_arbiter: table vectors, corner sequences and
// random transactions against a transaction-level model.
module tb_mod_add_arbiter;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int TO = 16;

   logic           clk_i;
   logic           rst_ni;
   logic [N-1:0]   req_valid_i;
   logic [N-1:0]   req_ready_o;
   logic [N*W-1:0] req_a_i;
   logic [N*W-1:0] req_b_i;
   logic [N*W-1:0] req_p_i;
   logic [N-1:0]   resp_valid_o;
   logic [N-1:0]   resp_ready_i;
   logic [W-1:0]   resp_result_o;
   logic           resp_err_o;
   logic           add_start_o;
   logic [W-1:0]   add_a_o;
   logic [W-1:0]   add_b_o;
   logic [W-1:0]   add_p_o;
   logic           add_finish_i;
   logic [W-1:0]   add_result_i;
   logic           busy_o;

   int tests = 0;
   int fails = 0;
   int ad_lat;
   bit ad_en;
   int ad_cnt;
   bit ad_pend;
   logic [W-1:0] ad_res;
   int last;

   mod_add_arbiter #(
      .NUM_REQ(N),
      .WIDTH  (W),
      .TIMEOUT(TO)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_p_i      (req_p_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_result_o(resp_result_o),
      .resp_err_o   (resp_err_o),
      .add_start_o  (add_start_o),
      .add_a_o      (add_a_o),
      .add_b_o      (add_b_o),
      .add_p_o      (add_p_o),
      .add_finish_i (add_finish_i),
      .add_result_i (add_result_i),
      .busy_o       (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] modadd(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic [W-1:0] p
   );
      logic [W:0] s;
      if (p == '0) return '0;
      s = {1'b0, a} + {1'b0, b};
      return W'(s % {1'b0, p});
   endfunction

   // Adder model with programmable latency; finish may be suppressed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         add_finish_i <= 1'b0;
         add_result_i <= '0;
         ad_pend      <= 1'b0;
         ad_cnt       <= 0;
         ad_res       <= '0;
      end else begin
         add_finish_i <= 1'b0;
         if (add_start_o) begin
            ad_res <= modadd(add_a_o, add_b_o, add_p_o);
            if (ad_lat <= 1) begin
               add_finish_i <= ad_en;
               add_result_i <= modadd(add_a_o, add_b_o, add_p_o);
               ad_pend      <= 1'b0;
            end else begin
               ad_pend <= 1'b1;
               ad_cnt  <= ad_lat - 1;
            end
         end else if (ad_pend) begin
            if (ad_cnt <= 1) begin
               ad_pend      <= 1'b0;
               add_finish_i <= ad_en;
               add_result_i <= ad_res;
            end else begin
               ad_cnt <= ad_cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Round-robin rule: first valid after the last served requester.
   function automatic int pick(input logic [N-1:0] vm, input int lst);
      for (int i = 1; i <= N; i++) begin
         if (vm[(lst + i) % N]) return (lst + i) % N;
      end
      return -1;
   endfunction

   // Entered at posedge+1 of an idle cycle with requests driven.
   task automatic run_txn(input int g, input logic [W-1:0] r,
                          input logic e, input int hold);
      logic [N-1:0] oh;
      logic [N-1:0] rnd;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic [W-1:0] ep;
      int c;
      int exp_c;
      oh    = '0;
      oh[g] = 1'b1;
      ea    = req_a_i[g*W +: W];
      eb    = req_b_i[g*W +: W];
      ep    = req_p_i[g*W +: W];
      exp_c = e ? 2 + TO : 2 + ad_lat;
      @(negedge clk_i);
      chk("req_ready", W'(req_ready_o), W'(oh));
      chk("busy_idle", W'(busy_o), '0);
      tick();
      req_valid_i[g] = 1'b0;
      @(negedge clk_i);
      chk("start", W'(add_start_o), W'(1));
      chk("add_a", add_a_o, ea);
      chk("add_b", add_b_o, eb);
      chk("add_p", add_p_o, ep);
      chk("ready_busy", W'(req_ready_o), '0);
      c = 1;
      while (c < exp_c + 4) begin
         tick();
         c++;
         @(negedge clk_i);
         if (resp_valid_o != '0) break;
         if (add_start_o || req_ready_o != '0 || add_a_o != ea) begin
            chk("wait_stable", {add_start_o, W'(req_ready_o)}, '0);
         end
      end
      chk("resp_cycle", W'(c), W'(exp_c));
      chk("resp_valid", W'(resp_valid_o), W'(oh));
      chk("result", resp_result_o, r);
      chk("err", W'(resp_err_o), W'(e));
      for (int h = 0; h < hold; h++) begin
         rnd = N'($urandom) & ~oh;
         resp_ready_i = rnd;
         tick();
         @(negedge clk_i);
         chk("hold_valid", W'(resp_valid_o), W'(oh));
         chk("hold_result", resp_result_o, r);
         chk("hold_ready", W'(req_ready_o), '0);
      end
      resp_ready_i = oh | N'($urandom);
      tick();
      req_valid_i  = '0;
      resp_ready_i = '0;
      last = g;
      @(negedge clk_i);
      chk("resp_done", W'({resp_valid_o, busy_o}), '0);
      tick();
   endtask

   typedef struct {
      logic [N-1:0] vm;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
      logic [W-1:0] ainc;
      int           lat;
      bit           en;
      int           hold;
      int           g;
      logic [W-1:0] r;
      logic         e;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(
      input logic [N-1:0] vm, input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [W-1:0] p,
      input logic [W-1:0] ainc, input int lat, input bit en,
      input int hold, input int g, input logic [W-1:0] r,
      input logic e
   );
      vec_t v;
      v.vm = vm; v.a = a; v.b = b; v.p = p; v.ainc = ainc;
      v.lat = lat; v.en = en; v.hold = hold; v.g = g;
      v.r = r; v.e = e;
      return v;
   endfunction

   task automatic drive_all(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] p, input logic [W-1:0] inc);
      for (int k = 0; k < N; k++) begin
         req_a_i[k*W +: W] = a + W'(k) * inc;
         req_b_i[k*W +: W] = b;
         req_p_i[k*W +: W] = p;
      end
   endtask

   initial begin
      logic [N-1:0] vm;
      logic [W-1:0] pa;
      logic [W-1:0] ra;
      logic e;
      int g;

      tbl[0]  = mk(4'hF, 64'd0, 64'd1, 64'd100, 64'd1, 1, 1, 0, 0, 64'd1, 1'b0);
      tbl[1]  = mk(4'hF, 64'd0, 64'd1, 64'd100, 64'd1, 1, 1, 0, 1, 64'd2, 1'b0);
      tbl[2]  = mk(4'hF, 64'd0, 64'd1, 64'd100, 64'd1, 1, 1, 0, 2, 64'd3, 1'b0);
      tbl[3]  = mk(4'hF, 64'd0, 64'd1, 64'd100, 64'd1, 1, 1, 0, 3, 64'd4, 1'b0);
      tbl[4]  = mk(4'hF, 64'd0, 64'd1, 64'd100, 64'd1, 1, 1, 0, 0, 64'd1, 1'b0);
      tbl[5]  = mk(4'h1, 64'd5, 64'd7, 64'd11, 64'd0, 1, 1, 0, 0, 64'd1, 1'b0);
      tbl[6]  = mk(4'hD, 64'd10, 64'd20, 64'd25, 64'd0, 1, 1, 5, 2, 64'd5, 1'b0);
      tbl[7]  = mk(4'h8, 64'd1, 64'd1, 64'd3, 64'd0, 1, 0, 1, 3, 64'd0, 1'b1);
      tbl[8]  = mk(4'h1, 64'd3, 64'd4, 64'd5, 64'd0, 2, 1, 0, 0, 64'd2, 1'b0);
      tbl[9]  = mk(4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1, 0, 1, 64'd4, 1'b0);
      tbl[10] = mk(4'h4, 64'd7, 64'd8, 64'd9, 64'd0, 16, 1, 0, 2, 64'd6, 1'b0);
      tbl[11] = mk(4'h4, 64'd7, 64'd8, 64'd9, 64'd0, 17, 1, 0, 2, 64'd0, 1'b1);

      rst_ni       = 1'b0;
      req_valid_i  = '1;
      resp_ready_i = '0;
      req_a_i      = '0;
      req_b_i      = '0;
      req_p_i      = '0;
      ad_lat       = 1;
      ad_en        = 1'b1;
      last         = N - 1;
      #3;
      chk("rst_ready", W'(req_ready_o), '0);
      chk("rst_busy", W'(busy_o), '0);
      chk("rst_start", W'(add_start_o), '0);
      chk("rst_resp", W'({resp_valid_o, resp_err_o}), '0);
      chk("rst_result", resp_result_o, '0);
      chk("rst_add_a", add_a_o, '0);
      req_valid_i = '0;
      tick();
      rst_ni = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         drive_all(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].ainc);
         ad_lat      = tbl[i].lat;
         ad_en       = tbl[i].en;
         req_valid_i = tbl[i].vm;
         chk("tbl_model_grant", W'(pick(tbl[i].vm, last)), W'(tbl[i].g));
         run_txn(tbl[i].g, tbl[i].r, tbl[i].e, tbl[i].hold);
      end

      // Reset while waiting on an adder that never finishes.
      drive_all(64'd9, 64'd9, 64'd13, 64'd0);
      ad_en       = 1'b0;
      req_valid_i = 4'h4;
      @(negedge clk_i);
      chk("abort_grant", W'(req_ready_o), W'(4'h4));
      tick();
      req_valid_i = '0;
      tick();
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("abort_busy", W'(busy_o), '0);
      chk("abort_start", W'(add_start_o), '0);
      chk("abort_resp", W'({resp_valid_o, resp_err_o}), '0);
      chk("abort_result", resp_result_o, '0);
      chk("abort_add_p", add_p_o, '0);
      last = N - 1;
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk_i);
         chk("abort_no_resp", W'({resp_valid_o, busy_o}), '0);
      end
      tick();
      drive_all(64'd1, 64'd2, 64'd50, 64'd10);
      ad_en       = 1'b1;
      ad_lat      = 1;
      req_valid_i = '1;
      run_txn(0, 64'd3, 1'b0, 0);

      // Random traffic checked against the round-robin model.
      for (int t = 0; t < 40; t++) begin
         vm = N'($urandom_range(1, (1 << N) - 1));
         for (int k = 0; k < N; k++) begin
            pa = {$urandom, $urandom};
            if (pa == '0) pa = 64'd1;
            req_p_i[k*W +: W] = pa;
            req_a_i[k*W +: W] = {$urandom, $urandom} % pa;
            req_b_i[k*W +: W] = {$urandom, $urandom} % pa;
         end
         ad_lat = $urandom_range(1, 20);
         ad_en  = ($urandom_range(0, 7) != 0);
         g      = pick(vm, last);
         e      = !ad_en || (ad_lat > TO);
         ra     = e ? '0 : modadd(req_a_i[g*W +: W], req_b_i[g*W +: W],
                                  req_p_i[g*W +: W]);
         req_valid_i = vm;
         run_txn(g, ra, e, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
